// File: rtl/servo_pkg.sv
// Shared servo types and default duty constants for the ramp controller.
package servo_pkg;

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [7:0] RST_DUTY = 8'd128;
  localparam logic [7:0] DMIN     = 8'd16;
  localparam logic [7:0] DMAX     = 8'd240;

endpackage

// File: rtl/ramp_tick.sv
// Ramp prescaler: counts 0..PRESC-1 while en is high, tick on the last count.
// Held at 0 whenever en is low, so every ramp starts from a full period.
module ramp_tick #(
  parameter int PRESC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESC);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (rst || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// Servo duty ramp: accepts a target in IDLE, slews duty_out by STEP every PRESC cycles, one-cycle done.
// Commands are refused (cmd_ready low) during a ramp and in reset; SERVO_RAMP_CLAMP_EN clamps targets.
module servo_ramp #(
  parameter int           W        = 8,
  parameter int           PRESC    = 50000,
  parameter int           STEP     = 1,
  parameter logic [W-1:0] RST_DUTY = servo_pkg::RST_DUTY,
  parameter logic [W-1:0] DMIN     = servo_pkg::DMIN,
  parameter logic [W-1:0] DMAX     = servo_pkg::DMAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [W-1:0] cmd_target,
  output logic         cmd_ready,
  output logic [W-1:0] duty_out,
  output logic         busy,
  output logic         done
);

  import servo_pkg::*;

  localparam logic [W:0] STEP_W = (W + 1)'(STEP);

  if (PRESC < 2 || STEP < 1 || DMIN > RST_DUTY || RST_DUTY > DMAX) begin : g_bad_cfg
    $error("servo_ramp: inconsistent parameters");
  end

  state_t       state;
  logic [W-1:0] target_q;
  logic [W-1:0] eff_target;
  logic [W-1:0] next_duty;
  logic [W:0]   diff_up;
  logic [W:0]   diff_dn;
  logic         tick;

  assign busy      = (state == RAMP);
  assign cmd_ready = (state == IDLE) && !rst;

`ifdef SERVO_RAMP_CLAMP_EN
  always_comb begin
    eff_target = cmd_target;
    if (cmd_target < DMIN) begin
      eff_target = DMIN;
    end else if (cmd_target > DMAX) begin
      eff_target = DMAX;
    end
  end
`else
  assign eff_target = cmd_target;
`endif

  // Differences are W+1 bits wide; a full step is only taken when it cannot overshoot the target.
  always_comb begin
    diff_up   = {1'b0, target_q} - {1'b0, duty_out};
    diff_dn   = {1'b0, duty_out} - {1'b0, target_q};
    next_duty = target_q;
    if (target_q > duty_out) begin
      if (diff_up > STEP_W) begin
        next_duty = duty_out + STEP_W[W-1:0];
      end
    end else if (diff_dn > STEP_W) begin
      next_duty = duty_out - STEP_W[W-1:0];
    end
  end

  ramp_tick #(.PRESC(PRESC)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty_out <= RST_DUTY;
      target_q <= RST_DUTY;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            target_q <= eff_target;
            if (eff_target == duty_out) begin
              done <= 1'b1;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (tick) begin
            duty_out <= next_duty;
            if (next_duty == target_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Bench for servo_ramp: a STEP=1 and a STEP=3 instance against a closed-form ramp model.
module tb_servo_ramp;

  localparam int PRESC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_target = 8'd0, b_target = 8'd0;
  logic       a_ready, b_ready, a_busy, b_busy, a_done, b_done;
  logic [7:0] a_duty, b_duty;

  int total = 0;
  int bad   = 0;
  int cur_a = 128;
  int cur_b = 128;

  always #5 clk = ~clk;

  servo_ramp #(.W(8), .PRESC(PRESC), .STEP(1)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_target(a_target),
    .cmd_ready(a_ready), .duty_out(a_duty), .busy(a_busy), .done(a_done)
  );

  servo_ramp #(.W(8), .PRESC(PRESC), .STEP(3)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_target(b_target),
    .cmd_ready(b_ready), .duty_out(b_duty), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_tgt(input int t);
`ifdef SERVO_RAMP_CLAMP_EN
    if (t < 16) return 16;
    if (t > 240) return 240;
`endif
    return t;
  endfunction

  task automatic drive(input int which, input logic v, input int t);
    if (which == 0) begin
      a_valid  = v;
      a_target = t[7:0];
    end else begin
      b_valid  = v;
      b_target = t[7:0];
    end
  endtask

  // Issue one command and follow the whole move cycle by cycle; optional noise offers junk commands mid-ramp.
  task automatic do_cmd(input int which, input int tgt, input bit noise, input string tag);
    int start, step, eff, diff, n, last, mv, expd;
    start = (which != 0) ? cur_b : cur_a;
    step  = (which != 0) ? 3 : 1;
    eff   = eff_tgt(tgt);
    diff  = (eff > start) ? eff - start : start - eff;
    n     = (diff + step - 1) / step;
    last  = PRESC * n;
    @(negedge clk);
    check({tag, "_ready_pre"}, (which != 0) ? b_ready : a_ready, 1);
    drive(which, 1'b1, tgt);
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      if (noise && k < last && $urandom_range(0, 3) == 0) drive(which, 1'b1, int'($urandom_range(0, 255)));
      else drive(which, 1'b0, 0);
      mv = (k / PRESC) * step;
      if (mv > diff) mv = diff;
      expd = (eff >= start) ? start + mv : start - mv;
      check({tag, "_duty"}, (which != 0) ? b_duty : a_duty, expd);
      check({tag, "_busy"}, (which != 0) ? b_busy : a_busy, (k < last) ? 1 : 0);
      check({tag, "_done"}, (which != 0) ? b_done : a_done, (k == last) ? 1 : 0);
    end
    check({tag, "_ready_post"}, (which != 0) ? b_ready : a_ready, 1);
    if (which != 0) cur_b = eff;
    else cur_a = eff;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready_in_reset", a_ready, 0);
    check("rst_duty_in_reset", a_duty, 128);
    rst = 1'b0;
    #1;
    check("rst_duty", a_duty, 128);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_ready, 1);
    check("rst_duty_b", b_duty, 128);

    do_cmd(0, 130, 1'b0, "basic");
    do_cmd(0, 128, 1'b0, "back");
    do_cmd(0, 128, 1'b0, "null");
    do_cmd(1, 133, 1'b0, "partial");
    do_cmd(0, 255, 1'b0, "clamp");
`ifdef SERVO_RAMP_CLAMP_EN
    check("clamp_final", a_duty, 240);
`else
    check("clamp_final", a_duty, 255);
`endif

    for (int i = 0; i < 12; i++) begin
      do_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b1, "rnd");
    end

    // Interruption: re-centre, ramp toward 140, offer 50 mid-ramp, then reset at duty 135.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_a = 128;
    cur_b = 128;
    drive(0, 1'b1, 140);
    for (int k = 0; k <= 29; k++) begin
      @(negedge clk);
      drive(0, (k == 5) ? 1'b1 : 1'b0, 50);
      check("intr_duty", a_duty, 128 + k / PRESC);
      check("intr_busy", a_busy, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("intr_rst_duty", a_duty, 128);
    check("intr_rst_busy", a_busy, 0);
    check("intr_rst_done", a_done, 0);
    check("intr_rst_ready", a_ready, 0);
    check("intr_rst_duty_b", b_duty, 128);
    rst = 1'b0;
    #1;
    check("intr_ready_after", a_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("intr_no_done", a_done, 0);
      check("intr_hold_duty", a_duty, 128);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
